// File: rtl/alu_serial_ctrl_pkg.sv
// Shared types and constants for the bit-serial ALU controller.
package alu_serial_ctrl_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcode layout: {AInvert, BInvert, Operacion[1:0]}
    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_OR  = 4'b0001;
    localparam logic [3:0] OPC_ADD = 4'b0010;
    localparam logic [3:0] OPC_SUB = 4'b0110;
    localparam logic [3:0] OPC_SLT = 4'b0111;
    localparam logic [3:0] OPC_NOR = 4'b1100;

    function automatic logic is_addsub(input logic [3:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Host request/response and 1-bit slice signals of the serial ALU controller.
interface alu_serial_ctrl_if;
    import alu_serial_ctrl_pkg::*;

    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             s_a;
    logic             s_b;
    logic             s_less;
    logic             s_cin;
    logic             s_ainv;
    logic             s_binv;
    logic [1:0]       s_op;
    logic             s_res;
    logic             s_cout;

    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry;
    logic             busy;
    logic             done;

    // Environment side: host requests plus the slice's return path
    modport master (
        output start, opcode, op_a, op_b, s_res, s_cout,
        input  s_a, s_b, s_less, s_cin, s_ainv, s_binv, s_op,
        input  result, zero, overflow, carry, busy, done
    );

    modport slave (
        input  start, opcode, op_a, op_b, s_res, s_cout,
        output s_a, s_b, s_less, s_cin, s_ainv, s_binv, s_op,
        output result, zero, overflow, carry, busy, done
    );

endinterface

// File: rtl/alu_bit_sequencer.sv
// IDLE/RUN/DONE control FSM and bit index counter for the serial ALU.
module alu_bit_sequencer
    import alu_serial_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_load,
    output logic             o_run,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic             w_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_load) begin
            r_idx <= '0;
        end else if (r_state == ST_RUN) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = ST_RUN;
                    w_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_idx == '1) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign o_idx  = r_idx;
    assign o_load = w_load;
    assign o_run  = (r_state == ST_RUN);
    assign o_last = (r_state == ST_RUN) && (r_idx == '1);
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE);

endmodule

// File: rtl/alu_serial_ctrl.sv
// Drives an external 1-bit ALU slice over 16 bits, LSB first, and collects result/flags.
module alu_serial_ctrl
    import alu_serial_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    alu_serial_ctrl_if.slave bus
);

    logic [IDX_W-1:0] w_idx;
    logic             w_load;
    logic             w_run;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_opc;
    logic             r_cy;
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_carry;

    logic             w_is_slt;
    logic             w_ovf_raw;
    logic [WIDTH-1:0] w_final;

    alu_bit_sequencer u_seq (
        .clk     (clk),
        .reset   (reset),
        .i_start (bus.start),
        .o_idx   (w_idx),
        .o_load  (w_load),
        .o_run   (w_run),
        .o_last  (w_last),
        .o_busy  (w_busy),
        .o_done  (w_done)
    );

    assign w_is_slt  = (r_opc == OPC_SLT);
    assign w_ovf_raw = r_cy ^ bus.s_cout;
    // SLT reports the sign of the difference corrected for signed overflow
    assign w_final   = w_is_slt ? {{(WIDTH-1){1'b0}}, bus.s_res ^ w_ovf_raw}
                                : {bus.s_res, r_acc};

    always_comb begin
        bus.s_a    = 1'b0;
        bus.s_b    = 1'b0;
        bus.s_less = 1'b0;
        bus.s_cin  = 1'b0;
        bus.s_ainv = 1'b0;
        bus.s_binv = 1'b0;
        bus.s_op   = 2'b00;
        if (w_run) begin
            bus.s_a    = r_a[w_idx];
            bus.s_b    = r_b[w_idx];
            bus.s_cin  = r_cy;
            bus.s_ainv = r_opc[3];
            bus.s_binv = r_opc[2];
            bus.s_op   = w_is_slt ? 2'b10 : r_opc[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_opc    <= '0;
            r_cy     <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_carry  <= 1'b0;
        end else if (w_load) begin
            r_a   <= bus.op_a;
            r_b   <= bus.op_b;
            r_opc <= bus.opcode;
            r_cy  <= bus.opcode[2];
        end else if (w_run) begin
            r_cy <= bus.s_cout;
            if (w_last) begin
                r_result <= w_final;
                r_zero   <= (w_final == '0);
                r_ovf    <= is_addsub(r_opc) & w_ovf_raw;
                r_carry  <= is_addsub(r_opc) & bus.s_cout;
            end else begin
                r_acc[w_idx] <= bus.s_res;
            end
        end
    end

    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_ovf;
    assign bus.carry    = r_carry;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;

endmodule
